word_bank: RTL and testbench
============================

# word_bank

Parametrised, clocked successor to the 4×8 latch-based byte memory. Holds DEPTH words of WIDTH bits in flip-flops, with one write port and one registered read port. Writes are triggered by a raw push-button input, which is synchronised and edge-detected so that each press produces exactly one write. The block adds per-word valid tracking, a synchronous clear and a saturating write counter. It sits between the switch/button inputs and the LED outputs of the board top level.

## Interface
- WIDTH, 8, bits per word
- DEPTH, 4, number of words (≥2); ADDR_W = $clog2(DEPTH)
- CNT_W, 8, width of saturating write counter

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_data  in  WIDTH  write data, sampled on the write edge
- wr_addr  in  ADDR_W  write address, sampled on the write edge
- store_btn  in  1  raw, asynchronous store button (level)
- clear  in  1  synchronous clear of all words and valid bits
- rd_addr  in  ADDR_W  read address
- rd_data  out  WIDTH  registered read data
- rd_valid  out  1  registered valid bit of the word at rd_addr
- full  out  1  all DEPTH valid bits set (combinational from valid register)
- wr_pulse  out  1  one-cycle internal write strobe (debug/LED)
- wr_count  out  CNT_W  number of accepted writes, saturating

## Operation
- Button path:
  - 2-FF synchroniser s1→s2, then delay flop s3.
  - wr_pulse = s2 & ~s3, so a button held high for any number of cycles gives exactly one pulse.
  - Button release generates nothing.
- Write:
  - On a clock edge with wr_pulse=1 and clear=0: mem[wr_addr] ← wr_data, valid[wr_addr] ← 1, wr_count ← min(wr_count+1, 2^CNT_W−1).
- Clear:
  - On an edge with clear=1: all mem ← 0 and all valid ← 0.
  - wr_count is not changed by clear.
  - Clear has priority. A simultaneous wr_pulse is dropped and is not counted.
- Read:
  - Every edge: rd_data ← mem[rd_addr] and rd_valid ← valid[rd_addr], both using next-state values.
  - Write-first bypass: if a write to rd_addr occurs on the same edge, rd_data takes wr_data and rd_valid takes 1.
  - If clear is asserted on that edge, rd_data ← 0 and rd_valid ← 0.
- Out-of-range addresses (DEPTH not a power of 2, addr ≥ DEPTH):
  - A write to such an address is ignored and not counted.
  - A read of such an address returns 0 with rd_valid=0.
- full = &valid.

## Timing
- Reset values: all mem 0, valid 0, s1/s2/s3 0, rd_data 0, rd_valid 0, full 0, wr_pulse 0, wr_count 0.
- Button latency:
  - store_btn first sampled high at edge E0.
  - wr_pulse is high for the cycle between E1 and E2.
  - The memory is written at E2.
  - rd_data reflects the write at E2 when rd_addr matches.
- Read latency: 1 cycle from a rd_addr change to rd_data/rd_valid.
- Button presses separated by ≥1 low sample each produce one write. A single-cycle glitch that is captured by s1 still produces one write; debouncing is out of scope.
- Reset mid-operation: reset is asynchronous and clears everything immediately, including the synchroniser.
  - If the button is still held at deassertion, one new write fires 2 edges later, because s3 was reset to 0.
- Saturation: at wr_count = 2^CNT_W−1, further writes still update memory but the count holds.

## Structure
- Package word_bank_pkg:
  - default parameter constants WIDTH_DEF=8, DEPTH_DEF=4, CNT_W_DEF=8;
  - helper function addr_w(depth).
- Sub-module btn_edge_sync: clk, rst_n, async_in → pulse. It contains the 2-FF synchroniser plus the rising-edge detector and is reusable for other buttons.
- Memory array, valid vector, read register and counter stay in word_bank.

## Test plan
- Reset, then hold store_btn 10 cycles with wr_addr=2, wr_data=8'hA5 → exactly one wr_pulse, mem[2]=A5, wr_count=1, rd_addr=2 gives rd_data=A5/rd_valid=1 at the write edge (bypass).
- Write 11, 22, 33, 44 to addresses 0..3 with four separate presses → full=1 after the 4th write, each read returns its value 1 cycle after rd_addr changes, wr_count=4.
- Assert clear on the same edge as a wr_pulse to addr 1 → all rd_data=0, rd_valid=0, full=0, wr_count unchanged.
- CNT_W=2, five presses → wr_count sequence 1, 2, 3, 3, 3 and the last write still lands in memory.
- Assert rst_n low mid-press with the button still held, then release reset → all outputs 0, then exactly one write 2 edges after deassertion.
- DEPTH=3, write to address 3 → no memory change, wr_count unchanged, read of address 3 returns 0/rd_valid=0.

Source files
------------

// File: rtl/word_bank_pkg.sv
// Shared defaults and helpers for the word_bank register memory.
package word_bank_pkg;

   localparam int unsigned WIDTH_DEF = 8;
   localparam int unsigned DEPTH_DEF = 4;
   localparam int unsigned CNT_W_DEF = 8;

   // Address width for a given depth; never narrower than one bit.
   function automatic int unsigned addr_w(input int unsigned depth);
      return (depth > 1) ? int'($clog2(depth)) : 1;
   endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for a raw button level.
module btn_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic pulse
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= async_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // One cycle high on the first synchronised high sample only.
   assign pulse = s2 & ~s3;

endmodule

// File: rtl/word_bank.sv
// Flop-based word memory written by a synchronised button press, with valid
// tracking, synchronous clear, write-first registered read and a write counter.
module word_bank
   import word_bank_pkg::*;
#(
   parameter  int unsigned WIDTH  = WIDTH_DEF,
   parameter  int unsigned DEPTH  = DEPTH_DEF,
   parameter  int unsigned CNT_W  = CNT_W_DEF,
   localparam int unsigned ADDR_W = addr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              store_btn,
   input  logic              clear,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic              wr_pulse,
   output logic [CNT_W-1:0]  wr_count
);

   localparam logic [ADDR_W:0]  DEPTH_V = (ADDR_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] valid;

   logic             wr_en;
   logic             rd_ok;
   logic [WIDTH-1:0] rd_data_nxt;
   logic             rd_valid_nxt;

   btn_edge_sync u_btn (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (store_btn),
      .pulse    (wr_pulse)
   );

   // Accepted write: clear wins, out-of-range addresses are dropped.
   always_comb begin
      wr_en        = wr_pulse & ~clear & ({1'b0, wr_addr} < DEPTH_V);
      rd_ok        = ({1'b0, rd_addr} < DEPTH_V);
      rd_data_nxt  = '0;
      rd_valid_nxt = 1'b0;
      if (!clear) begin
         if (wr_en && (wr_addr == rd_addr)) begin
            rd_data_nxt  = wr_data;
            rd_valid_nxt = 1'b1;
         end else if (rd_ok) begin
            rd_data_nxt  = mem[rd_addr];
            rd_valid_nxt = valid[rd_addr];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem   <= '{default: '0};
         valid <= '0;
      end else if (clear) begin
         mem   <= '{default: '0};
         valid <= '0;
      end else if (wr_en) begin
         mem[wr_addr]   <= wr_data;
         valid[wr_addr] <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_data  <= rd_data_nxt;
         rd_valid <= rd_valid_nxt;
      end
   end

   // Saturating count of accepted writes; clear leaves it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_count <= '0;
      end else if (wr_en && (wr_count != CNT_MAX)) begin
         wr_count <= wr_count + CNT_W'(1);
      end
   end

   assign full = &valid;

endmodule

// File: tb/tb_word_bank.sv
// Directed scoreboard bench for word_bank: default, narrow-counter and DEPTH=3 instances.
module tb_word_bank;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       store_btn = 1'b0;
   logic       clear     = 1'b0;
   logic [7:0] wr_data   = '0;
   logic [1:0] wr_addr   = '0;
   logic [1:0] rd_addr   = '0;

   logic [7:0] m_rd_data, s_rd_data, o_rd_data;
   logic       m_rd_valid, s_rd_valid, o_rd_valid;
   logic       m_full, s_full, o_full;
   logic       m_pulse, s_pulse, o_pulse;
   logic [7:0] m_count, o_count;
   logic [1:0] s_count;

   always #5 clk = ~clk;

   word_bank u_main (
      .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_addr(wr_addr),
      .store_btn(store_btn), .clear(clear), .rd_addr(rd_addr),
      .rd_data(m_rd_data), .rd_valid(m_rd_valid), .full(m_full),
      .wr_pulse(m_pulse), .wr_count(m_count)
   );

   word_bank #(.CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_addr(wr_addr),
      .store_btn(store_btn), .clear(clear), .rd_addr(rd_addr),
      .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full),
      .wr_pulse(s_pulse), .wr_count(s_count)
   );

   word_bank #(.DEPTH(3)) u_odd (
      .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_addr(wr_addr),
      .store_btn(store_btn), .clear(clear), .rd_addr(rd_addr),
      .rd_data(o_rd_data), .rd_valid(o_rd_valid), .full(o_full),
      .wr_pulse(o_pulse), .wr_count(o_count)
   );

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t       sb[$];
   int         checks    = 0;
   int         errors    = 0;
   int         pulse_cnt = 0;
   int         base      = 0;
   logic [7:0] pd [4]    = '{8'h11, 8'h22, 8'h33, 8'h44};

   always @(posedge clk) if (m_pulse) pulse_cnt++;

   task automatic exp_push(input string tag, input logic [31:0] v);
      sb.push_back('{tag, v});
   endtask

   task automatic chk(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty: observed %0h required nothing", obs);
         return;
      end
      e = sb.pop_front();
      assert (obs === e.val) else begin
         errors++;
         $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; store_btn = 1'b0; clear = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic press(input logic [1:0] a, input logic [7:0] d);
      wr_addr = a; wr_data = d; store_btn = 1'b1;
      repeat (3) tick();
      store_btn = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      tick(); tick();
      exp_push("rst_rd_data", 32'h0);  chk(32'(m_rd_data));
      exp_push("rst_rd_valid", 32'h0); chk(32'(m_rd_valid));
      exp_push("rst_full", 32'h0);     chk(32'(m_full));
      exp_push("rst_pulse", 32'h0);    chk(32'(m_pulse));
      exp_push("rst_count", 32'h0);    chk(32'(m_count));
      rst_n = 1'b1;
      tick();

      // Long press: one pulse, bypass read on the write edge
      wr_addr = 2'd2; wr_data = 8'hA5; rd_addr = 2'd2;
      base = pulse_cnt;
      store_btn = 1'b1;
      for (int i = 0; i < 14; i++) begin
         if (i == 1) exp_push("p1_pulse_e1", 32'h1);
         if (i == 2) begin
            exp_push("p1_rd_data", 32'hA5);
            exp_push("p1_rd_valid", 32'h1);
            exp_push("p1_count", 32'h1);
         end
         if (i == 10) store_btn = 1'b0;
         tick();
         if (i == 1) chk(32'(m_pulse));
         if (i == 2) begin
            chk(32'(m_rd_data)); chk(32'(m_rd_valid)); chk(32'(m_count));
         end
      end
      exp_push("p1_pulse_total", 32'h1);
      chk(32'(pulse_cnt - base));

      // Four presses to addresses 0..3
      do_reset();
      rd_addr = 2'd3;
      for (int i = 0; i < 4; i++) begin
         exp_push("p2_sat_count", (i < 3) ? 32'(i + 1) : 32'h3);
         if (i == 2) exp_push("p2_full_early", 32'h0);
         press(2'(i), pd[i]);
         chk(32'(s_count));
         if (i == 2) chk(32'(m_full));
      end
      exp_push("p2_full", 32'h1);       chk(32'(m_full));
      exp_push("p2_count", 32'h4);      chk(32'(m_count));
      exp_push("p2_odd_count", 32'h3);  chk(32'(o_count));
      exp_push("p2_odd_full", 32'h1);   chk(32'(o_full));
      for (int a = 0; a < 4; a++) begin
         rd_addr = 2'(a);
         if (a > 0) begin
            exp_push("p2_rd_hold", 32'(pd[a-1]));
            #1 chk(32'(m_rd_data));
         end
         exp_push("p2_rd_data", 32'(pd[a]));
         exp_push("p2_rd_valid", 32'h1);
         exp_push("p2_odd_rd_data", (a < 3) ? 32'(pd[a]) : 32'h0);
         exp_push("p2_odd_rd_valid", (a < 3) ? 32'h1 : 32'h0);
         tick();
         chk(32'(m_rd_data)); chk(32'(m_rd_valid));
         chk(32'(o_rd_data)); chk(32'(o_rd_valid));
      end
      exp_push("p2_sat_count5", 32'h3);
      exp_push("p2_count5", 32'h5);
      exp_push("p2_odd_count5", 32'h4);
      press(2'd1, 8'h55);
      chk(32'(s_count)); chk(32'(m_count)); chk(32'(o_count));
      rd_addr = 2'd1;
      exp_push("p2_sat_rd_data", 32'h55);
      exp_push("p2_sat_rd_valid", 32'h1);
      tick();
      chk(32'(s_rd_data)); chk(32'(s_rd_valid));

      // Clear on the same edge as a write pulse
      wr_addr = 2'd1; wr_data = 8'h99; rd_addr = 2'd1;
      store_btn = 1'b1;
      tick(); tick();
      exp_push("p3_pulse", 32'h1);
      chk(32'(m_pulse));
      clear = 1'b1;
      exp_push("p3_rd_data", 32'h0);
      exp_push("p3_rd_valid", 32'h0);
      exp_push("p3_full", 32'h0);
      exp_push("p3_count", 32'h5);
      tick();
      clear = 1'b0;
      chk(32'(m_rd_data)); chk(32'(m_rd_valid));
      chk(32'(m_full)); chk(32'(m_count));
      for (int a = 0; a < 4; a++) begin
         rd_addr = 2'(a);
         exp_push("p3_rd_all", 32'h0);
         exp_push("p3_valid_all", 32'h0);
         tick();
         chk(32'(m_rd_data)); chk(32'(m_rd_valid));
      end
      store_btn = 1'b0;
      repeat (3) tick();
      exp_push("p3_count_after", 32'h5);
      chk(32'(m_count));

      // Asynchronous reset mid-press with the button held
      wr_addr = 2'd0; wr_data = 8'h77; rd_addr = 2'd0;
      store_btn = 1'b1;
      tick(); tick();
      rst_n = 1'b0;
      exp_push("p4_rst_pulse", 32'h0);
      exp_push("p4_rst_count", 32'h0);
      exp_push("p4_rst_full", 32'h0);
      exp_push("p4_rst_rd_data", 32'h0);
      exp_push("p4_rst_rd_valid", 32'h0);
      #1;
      chk(32'(m_pulse)); chk(32'(m_count)); chk(32'(m_full));
      chk(32'(m_rd_data)); chk(32'(m_rd_valid));
      tick(); tick();
      rst_n = 1'b1;
      base = pulse_cnt;
      exp_push("p4_pulse_d1", 32'h0);
      tick(); chk(32'(m_pulse));
      exp_push("p4_pulse_d2", 32'h1);
      tick(); chk(32'(m_pulse));
      exp_push("p4_count_d3", 32'h1);
      exp_push("p4_rd_data_d3", 32'h77);
      exp_push("p4_rd_valid_d3", 32'h1);
      tick();
      chk(32'(m_count)); chk(32'(m_rd_data)); chk(32'(m_rd_valid));
      repeat (5) tick();
      store_btn = 1'b0;
      repeat (3) tick();
      exp_push("p4_pulse_total", 32'h1);
      chk(32'(pulse_cnt - base));
      exp_push("p4_count_final", 32'h1);
      chk(32'(m_count));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
